// File: rtl/rx_pkg.sv
// rtl/rx_pkg.sv - shared types and defaults for the QPSK receiver sequencer
//
// Contents:
//   rx_state_e        sequencer state encoding (matches state_o)
//   RX_*_DEF          default timing parameters
//   RX_ERR_W          width of the accumulated square error
//   RX_PHASE_W        width of the symbol phase selector
//   rx_cnt_width()    symbol counter width for a given acquisition length

package rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_FLUSH   = 2'b01,
        ST_ACQUIRE = 2'b10,
        ST_TRACK   = 2'b11
    } rx_state_e;

    localparam int RX_SAM_DIV_DEF    = 4;
    localparam int RX_SPS_DEF        = 4;
    localparam int RX_FLUSH_SYMS_DEF = 24;
    localparam int RX_ACQ_LOG2_DEF   = 8;
    localparam int RX_ERR_W          = 52;
    localparam int RX_PHASE_W        = 4;

    // The counter must hold 2**acq_log2 - 1 and any flush length up to 255.
    function automatic int rx_cnt_width(input int acq_log2);
        return (acq_log2 + 1 > 8) ? acq_log2 + 1 : 8;
    endfunction

endpackage

// File: rtl/rx_clk_enable_gen.sv
// rtl/rx_clk_enable_gen.sv - free-running sample/symbol enable generator with glitch-free phase select
//
// Ports:
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   sym_phase_i      requested symbol phase (sample offset within a symbol); >= SPS is clamped to SPS-1
//   sam_clk_ena_o    one-clk pulse every SAM_DIV clocks (registered)
//   sym_clk_ena_o    sample pulse whose symbol position equals the latched phase (registered)
//   phase_changed_o  one-clk pulse, coincident with sam_clk_ena_o, when a new phase was latched

module rx_clk_enable_gen
    import rx_pkg::*;
#(
    parameter int SAM_DIV = RX_SAM_DIV_DEF,
    parameter int SPS     = RX_SPS_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [RX_PHASE_W-1:0] sym_phase_i,
    output logic                  sam_clk_ena_o,
    output logic                  sym_clk_ena_o,
    output logic                  phase_changed_o
);

    localparam int SAM_W = $clog2(SAM_DIV);
    localparam logic [SAM_W-1:0]      SAM_LAST = SAM_W'(SAM_DIV - 1);
    localparam logic [RX_PHASE_W-1:0] SYM_LAST = RX_PHASE_W'(SPS - 1);
    localparam logic [RX_PHASE_W:0]   SPS_V    = (RX_PHASE_W + 1)'(SPS);

    logic [SAM_W-1:0]      sam_cnt_q, sam_cnt_d;
    logic [RX_PHASE_W-1:0] sym_cnt_q, sym_cnt_d;
    logic [RX_PHASE_W-1:0] phase_q, phase_d;
    logic [RX_PHASE_W-1:0] phase_new;
    logic                  sam_ena_q, sam_ena_d;
    logic                  sym_ena_q, sym_ena_d;
    logic                  chg_q, chg_d;
    logic                  tick;
    logic                  boundary;

    always_comb begin
        // tick is the last clk of a sample period; the registered enables
        // therefore rise on the edge that closes the period.
        tick      = (sam_cnt_q == SAM_LAST);
        boundary  = tick && (sym_cnt_q == SYM_LAST);
        phase_new = ({1'b0, sym_phase_i} >= SPS_V) ? SYM_LAST : sym_phase_i;

        sam_cnt_d = tick ? '0 : sam_cnt_q + SAM_W'(1);

        sym_cnt_d = sym_cnt_q;
        if (tick) begin
            sym_cnt_d = (sym_cnt_q == SYM_LAST) ? '0 : sym_cnt_q + RX_PHASE_W'(1);
        end

        // The phase only moves at the symbol boundary, so the old phase has
        // already had its pulse in this symbol and the new one starts fresh.
        phase_d   = boundary ? phase_new : phase_q;

        sam_ena_d = tick;
        sym_ena_d = tick && (sym_cnt_q == phase_q);
        chg_d     = boundary && (phase_new != phase_q);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sam_cnt_q <= '0;
            sym_cnt_q <= '0;
            phase_q   <= '0;
            sam_ena_q <= 1'b0;
            sym_ena_q <= 1'b0;
            chg_q     <= 1'b0;
        end else begin
            sam_cnt_q <= sam_cnt_d;
            sym_cnt_q <= sym_cnt_d;
            phase_q   <= phase_d;
            sam_ena_q <= sam_ena_d;
            sym_ena_q <= sym_ena_d;
            chg_q     <= chg_d;
        end
    end

    assign sam_clk_ena_o   = sam_ena_q;
    assign sym_clk_ena_o   = sym_ena_q;
    assign phase_changed_o = chg_q;

endmodule

// File: rtl/rx_sequencer.sv
// rtl/rx_sequencer.sv - QPSK receiver timing and flush/acquire/track sequencer
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   start        level; begin acquisition from IDLE
//   abort        level; return to IDLE from any state (highest priority)
//   sym_phase    symbol-enable sample offset, clamped to SPS-1
//   err_in       accumulated square error
//   err_thresh   loss-of-lock threshold (unsigned compare, err_in > err_thresh)
//   sam_clk_ena  one-clk pulse every SAM_DIV clocks
//   sym_clk_ena  one-clk pulse per symbol at the selected phase
//   nco_sync     one-clk pulse on IDLE -> FLUSH
//   ref_clear    one-clk pulse on IDLE -> FLUSH and TRACK -> ACQUIRE
//   ref_hold     1 in IDLE and FLUSH
//   locked       1 in TRACK
//   lost_lock    one-clk pulse on TRACK -> ACQUIRE
//   state_o      00 IDLE, 01 FLUSH, 10 ACQUIRE, 11 TRACK

module rx_sequencer
    import rx_pkg::*;
#(
    parameter int SAM_DIV    = RX_SAM_DIV_DEF,
    parameter int SPS        = RX_SPS_DEF,
    parameter int FLUSH_SYMS = RX_FLUSH_SYMS_DEF,
    parameter int ACQ_LOG2   = RX_ACQ_LOG2_DEF,
    parameter int ERR_W      = RX_ERR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [RX_PHASE_W-1:0] sym_phase,
    input  logic [ERR_W-1:0]      err_in,
    input  logic [ERR_W-1:0]      err_thresh,
    output logic                  sam_clk_ena,
    output logic                  sym_clk_ena,
    output logic                  nco_sync,
    output logic                  ref_clear,
    output logic                  ref_hold,
    output logic                  locked,
    output logic                  lost_lock,
    output logic [1:0]            state_o
);

    localparam int CNT_W = rx_cnt_width(ACQ_LOG2);
    // Exit on the pulse that completes the count; equality, never a wrap.
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_SYMS - 1);
    localparam logic [CNT_W-1:0] ACQ_LAST   = CNT_W'((1 << ACQ_LOG2) - 1);

    logic       sym_ena;
    logic       phase_chg;

    rx_clk_enable_gen #(
        .SAM_DIV (SAM_DIV),
        .SPS     (SPS)
    ) u_clk_enable_gen (
        .clk_i           (clk),
        .rst_ni          (reset),
        .sym_phase_i     (sym_phase),
        .sam_clk_ena_o   (sam_clk_ena),
        .sym_clk_ena_o   (sym_ena),
        .phase_changed_o (phase_chg)
    );

    assign sym_clk_ena = sym_ena;

    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             nco_sync_q, nco_sync_d;
    logic             ref_clear_q, ref_clear_d;
    logic             ref_hold_q, ref_hold_d;
    logic             locked_q, locked_d;
    logic             lost_lock_q, lost_lock_d;
    logic             err_over;

    assign err_over = sym_ena && (err_in > err_thresh);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        nco_sync_d  = 1'b0;
        ref_clear_d = 1'b0;
        lost_lock_d = 1'b0;

        if (abort) begin
            // Abort wins over start, counting and loss of lock alike, and
            // deliberately leaves the reference accumulators untouched.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d     = ST_FLUSH;
                        cnt_d       = '0;
                        nco_sync_d  = 1'b1;
                        ref_clear_d = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (sym_ena) begin
                        if (cnt_q == FLUSH_LAST) begin
                            state_d = ST_ACQUIRE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_ACQUIRE: begin
                    if (sym_ena) begin
                        if (cnt_q == ACQ_LAST) begin
                            state_d = ST_TRACK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_TRACK: begin
                    // Either cause alone or both together give a single
                    // re-entry into ACQUIRE.
                    if (phase_chg || err_over) begin
                        state_d     = ST_ACQUIRE;
                        cnt_d       = '0;
                        lost_lock_d = 1'b1;
                        ref_clear_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        ref_hold_d = (state_d == ST_IDLE) || (state_d == ST_FLUSH);
        locked_d   = (state_d == ST_TRACK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            nco_sync_q  <= 1'b0;
            ref_clear_q <= 1'b0;
            ref_hold_q  <= 1'b1;
            locked_q    <= 1'b0;
            lost_lock_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nco_sync_q  <= nco_sync_d;
            ref_clear_q <= ref_clear_d;
            ref_hold_q  <= ref_hold_d;
            locked_q    <= locked_d;
            lost_lock_q <= lost_lock_d;
        end
    end

    assign nco_sync  = nco_sync_q;
    assign ref_clear = ref_clear_q;
    assign ref_hold  = ref_hold_q;
    assign locked    = locked_q;
    assign lost_lock = lost_lock_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_rx_sequencer.sv
// tb/tb_rx_sequencer.sv - self-checking bench for rx_sequencer

module tb_rx_sequencer;

    localparam int SAM_DIV    = 4;
    localparam int SPS        = 4;
    localparam int FLUSH_SYMS = 24;
    localparam int ACQ_LOG2   = 8;
    localparam int ERR_W      = 52;
    localparam logic [8:0] RST_VEC = 9'b0_0_0_0_1_0_0_00;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [3:0]       sym_phase = 4'd0;
    logic [ERR_W-1:0] err_in = '0;
    logic [ERR_W-1:0] err_thresh = '0;
    logic             sam_clk_ena, sym_clk_ena, nco_sync, ref_clear;
    logic             ref_hold, locked, lost_lock;
    logic [1:0]       state_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rx_sequencer #(
        .SAM_DIV(SAM_DIV), .SPS(SPS), .FLUSH_SYMS(FLUSH_SYMS),
        .ACQ_LOG2(ACQ_LOG2), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .sym_phase(sym_phase), .err_in(err_in), .err_thresh(err_thresh),
        .sam_clk_ena(sam_clk_ena), .sym_clk_ena(sym_clk_ena),
        .nco_sync(nco_sync), .ref_clear(ref_clear), .ref_hold(ref_hold),
        .locked(locked), .lost_lock(lost_lock), .state_o(state_o)
    );

    // Reference model: enables from the edge count since reset release,
    // sequencer from "pulses seen in this state" compared against totals.
    int unsigned m_k = 0;
    int          m_syms = 0;
    int          m_n, m_pos;
    logic [3:0]  m_phase = 4'd0, m_np;
    logic [1:0]  m_state = 2'd0;
    bit          m_sam = 0, m_sym = 0, m_chg = 0, m_nco = 0, m_clr = 0, m_lost = 0;
    bit          m_psym, m_pchg;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_k = 0; m_syms = 0; m_phase = 4'd0; m_state = 2'd0;
            m_sam = 0; m_sym = 0; m_chg = 0; m_nco = 0; m_clr = 0; m_lost = 0;
        end else begin
            m_psym = m_sym;
            m_pchg = m_chg;
            m_nco = 0; m_clr = 0; m_lost = 0;
            if (abort) begin
                m_state = 2'd0; m_syms = 0;
            end else begin
                case (m_state)
                    2'd0: if (start) begin m_state = 2'd1; m_syms = 0; m_nco = 1; m_clr = 1; end
                    2'd1: if (m_psym) begin
                        m_syms++;
                        if (m_syms == FLUSH_SYMS) begin m_state = 2'd2; m_syms = 0; end
                    end
                    2'd2: if (m_psym) begin
                        m_syms++;
                        if (m_syms == (1 << ACQ_LOG2)) begin m_state = 2'd3; m_syms = 0; end
                    end
                    default: if (m_pchg || (m_psym && err_in > err_thresh)) begin
                        m_state = 2'd2; m_syms = 0; m_lost = 1; m_clr = 1;
                    end
                endcase
            end
            m_k++;
            m_sam = (m_k % SAM_DIV == 0);
            m_sym = 0;
            m_chg = 0;
            if (m_sam) begin
                m_n   = int'(m_k / SAM_DIV);
                m_pos = (m_n - 1) % SPS;
                m_sym = (m_pos == int'(m_phase));
                if (m_pos == SPS - 1) begin
                    m_np    = (sym_phase >= SPS) ? 4'(SPS - 1) : sym_phase;
                    m_chg   = (m_np != m_phase);
                    m_phase = m_np;
                end
            end
        end
    end

    logic [8:0] obs, exp_vec;
    assign obs     = {sam_clk_ena, sym_clk_ena, nco_sync, ref_clear, ref_hold, locked, lost_lock, state_o};
    assign exp_vec = {m_sam, m_sym, m_nco, m_clr, (m_state < 2'd2), (m_state == 2'd3), m_lost, m_state};

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [ERR_W-1:0] rnd52();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[ERR_W-1:0];
    endfunction

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2;
        n_vec++; if (obs !== RST_VEC) begin n_err++; $display("FAIL reset_values got %b want %b", obs, RST_VEC); end
        reset = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            n_vec++; if (sam_clk_ena !== (k % 4 == 0)) begin n_err++; $display("FAIL reset_sam clk %0d got %b want %b", k, sam_clk_ena, (k % 4 == 0)); end
            n_vec++; if (sym_clk_ena !== (k == 4 || k == 20 || k == 36)) begin n_err++; $display("FAIL reset_sym clk %0d got %b", k, sym_clk_ena); end
            n_vec++; if ({nco_sync, ref_clear, lost_lock, locked, ref_hold, state_o} !== 7'b000_0_1_00) begin n_err++; $display("FAIL reset_quiet clk %0d got %b want 0000100", k, {nco_sync, ref_clear, lost_lock, locked, ref_hold, state_o}); end
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL reset_model clk %0d got %b want %b", k, obs, exp_vec); end
        end
    endtask

    task automatic test_start_acquire();
        int fs = 0, as = 0;
        logic [1:0] pst;
        logic psym;
        start = 1'b1;
        cyc();
        start = 1'b0;
        n_vec++; if ({state_o, nco_sync, ref_clear} !== 4'b01_1_1) begin n_err++; $display("FAIL start_pulse got %b want 0111", {state_o, nco_sync, ref_clear}); end
        cyc();
        n_vec++; if ({nco_sync, ref_clear} !== 2'b00) begin n_err++; $display("FAIL start_single got %b want 00", {nco_sync, ref_clear}); end
        pst = state_o; psym = sym_clk_ena;
        for (int i = 0; i < 6000 && state_o !== 2'b11; i++) begin
            err_in = rnd52(); err_thresh = rnd52();
            cyc();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL acq_model t=%0t got %b want %b", $time, obs, exp_vec); end
            if (psym && pst == 2'b01) fs++;
            if (psym && pst == 2'b10) as++;
            pst = state_o; psym = sym_clk_ena;
        end
        err_in = '0; err_thresh = '1;
        n_vec++; if ({state_o, locked, ref_hold} !== 4'b11_1_0) begin n_err++; $display("FAIL reach_track got %b want 1110", {state_o, locked, ref_hold}); end
        n_vec++; if (fs !== FLUSH_SYMS) begin n_err++; $display("FAIL flush_count got %0d want %0d", fs, FLUSH_SYMS); end
        n_vec++; if (as !== (1 << ACQ_LOG2)) begin n_err++; $display("FAIL acq_count got %0d want %0d", as, 1 << ACQ_LOG2); end
    endtask

    task automatic test_err_thresh();
        bit got = 0;
        err_thresh = 52'd999;
        for (int i = 0; i < 80; i++) begin
            err_in = (i % 3 == 0) ? 52'd999 : 52'($urandom_range(0, 999));
            cyc();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL err_below_model i=%0d got %b want %b", i, obs, exp_vec); end
            n_vec++; if (state_o !== 2'b11) begin n_err++; $display("FAIL err_below_state i=%0d got %b want 11", i, state_o); end
        end
        err_thresh = 52'h8_0000_0000_0000;
        err_in     = 52'h7_FFFF_FFFF_FFFF;
        for (int i = 0; i < 40; i++) begin
            cyc();
            n_vec++; if (state_o !== 2'b11) begin n_err++; $display("FAIL err_wide_state i=%0d got %b want 11", i, state_o); end
        end
        err_thresh = 52'd999;
        err_in     = 52'd1000;
        for (int i = 0; i < 40 && !got; i++) begin
            cyc();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL err_above_model i=%0d got %b want %b", i, obs, exp_vec); end
            if (lost_lock === 1'b1) got = 1;
        end
        n_vec++; if (!got) begin n_err++; $display("FAIL err_lost_timeout got 0 want 1"); end
        n_vec++; if ({lost_lock, ref_clear, locked, ref_hold, state_o} !== 6'b1_1_0_0_10) begin n_err++; $display("FAIL err_lost_outputs got %b want 110010", {lost_lock, ref_clear, locked, ref_hold, state_o}); end
        cyc();
        err_in = '0;
        n_vec++; if ({lost_lock, ref_clear} !== 2'b00) begin n_err++; $display("FAIL err_lost_single got %b want 00", {lost_lock, ref_clear}); end
    endtask

    task automatic test_phase_change();
        int t[$];
        int nlost = 0, nclr = 0, g0 = -1, g1 = -1;
        bit got = 0;
        for (int i = 0; i < 5000 && state_o !== 2'b11; i++) begin
            cyc();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL phase_run_model t=%0t got %b want %b", $time, obs, exp_vec); end
        end
        n_vec++; if (state_o !== 2'b11) begin n_err++; $display("FAIL phase_reach_track got %b want 11", state_o); end
        for (int i = 0; i < 40 && !got; i++) begin
            cyc();
            if (sym_clk_ena === 1'b1) got = 1;
        end
        n_vec++; if (!got) begin n_err++; $display("FAIL phase_sym_timeout got 0 want 1"); end
        for (int i = 1; i <= 60; i++) begin
            if (i == 4) sym_phase = 4'd2;
            cyc();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL phase_model i=%0d got %b want %b", i, obs, exp_vec); end
            if (sym_clk_ena === 1'b1) t.push_back(i);
            if (lost_lock === 1'b1) nlost++;
            if (ref_clear === 1'b1) nclr++;
        end
        if (t.size() > 0) g0 = t[0];
        if (t.size() > 1) g1 = t[1];
        n_vec++; if (g0 != 24 || g1 != 40) begin n_err++; $display("FAIL phase_spacing got %0d,%0d want 24,40", g0, g1); end
        n_vec++; if (nlost != 1 || nclr != 1) begin n_err++; $display("FAIL phase_relock got lost=%0d clr=%0d want 1,1", nlost, nclr); end
        n_vec++; if ({state_o, locked} !== 3'b10_0) begin n_err++; $display("FAIL phase_state got %b want 100", {state_o, locked}); end
    endtask

    task automatic test_simultaneous();
        int nlost = 0, nclr = 0;
        bit got = 0;
        sym_phase = 4'd3;
        for (int i = 0; i < 5000 && state_o !== 2'b11; i++) begin
            cyc();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL simul_run_model t=%0t got %b want %b", $time, obs, exp_vec); end
        end
        n_vec++; if (state_o !== 2'b11) begin n_err++; $display("FAIL simul_reach_track got %b want 11", state_o); end
        for (int i = 0; i < 40 && !got; i++) begin
            cyc();
            if (sym_clk_ena === 1'b1) got = 1;
        end
        n_vec++; if (!got) begin n_err++; $display("FAIL simul_sym_timeout got 0 want 1"); end
        for (int i = 1; i <= 30; i++) begin
            if (i == 3) begin sym_phase = 4'd1; err_in = 52'd1000; err_thresh = 52'd999; end
            cyc();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL simul_model i=%0d got %b want %b", i, obs, exp_vec); end
            if (lost_lock === 1'b1) nlost++;
            if (ref_clear === 1'b1) nclr++;
        end
        n_vec++; if (nlost != 1 || nclr != 1) begin n_err++; $display("FAIL simul_single got lost=%0d clr=%0d want 1,1", nlost, nclr); end
        n_vec++; if (state_o !== 2'b10) begin n_err++; $display("FAIL simul_state got %b want 10", state_o); end
    endtask

    task automatic test_abort();
        err_in = 52'd5000; err_thresh = 52'd1;
        abort = 1'b1; start = 1'b1;
        cyc();
        abort = 1'b0;
        n_vec++; if ({state_o, lost_lock, locked, ref_hold, ref_clear, nco_sync} !== 7'b00_0_0_1_0_0) begin n_err++; $display("FAIL abort_outputs got %b want 0000100", {state_o, lost_lock, locked, ref_hold, ref_clear, nco_sync}); end
        cyc();
        start = 1'b0;
        n_vec++; if ({state_o, nco_sync, ref_clear} !== 4'b01_1_1) begin n_err++; $display("FAIL abort_restart got %b want 0111", {state_o, nco_sync, ref_clear}); end
        for (int i = 0; i < 400; i++) begin
            start     = ($urandom_range(0, 19) == 0);
            abort     = ($urandom_range(0, 29) == 0);
            sym_phase = 4'($urandom_range(0, 15));
            err_in    = rnd52();
            err_thresh = rnd52();
            cyc();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL random_model i=%0d got %b want %b", i, obs, exp_vec); end
        end
        start = 1'b0; abort = 1'b1;
        cyc();
        abort = 1'b0;
        n_vec++; if (state_o !== 2'b00) begin n_err++; $display("FAIL abort_idle got %b want 00", state_o); end
    endtask

    task automatic test_reset_mid();
        sym_phase = 4'd0; err_in = '0; err_thresh = '1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int i = 0; i < 1000 && state_o !== 2'b10; i++) begin
            cyc();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL mid_run_model t=%0t got %b want %b", $time, obs, exp_vec); end
        end
        n_vec++; if (state_o !== 2'b10) begin n_err++; $display("FAIL mid_reach_acq got %b want 10", state_o); end
        repeat (5) cyc();
        #3;
        reset = 1'b0;
        #1;
        n_vec++; if (obs !== RST_VEC) begin n_err++; $display("FAIL mid_async_reset got %b want %b", obs, RST_VEC); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_vec++; if (obs !== RST_VEC) begin n_err++; $display("FAIL mid_held_reset i=%0d got %b want %b", i, obs, RST_VEC); end
        end
        reset = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            n_vec++; if (obs !== exp_vec) begin n_err++; $display("FAIL mid_after_model k=%0d got %b want %b", k, obs, exp_vec); end
            n_vec++; if (sam_clk_ena !== (k % 4 == 0) || state_o !== 2'b00) begin n_err++; $display("FAIL mid_after k=%0d got sam=%b st=%b", k, sam_clk_ena, state_o); end
        end
    endtask

    initial begin
        test_reset();
        test_start_acquire();
        test_err_thresh();
        test_phase_change();
        test_simultaneous();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
